// File: rtl/regfile_wb_sched_pkg.sv
// Shared types and constants for the register-file write-port scheduler.
package regfile_wb_sched_pkg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NREG = 2 ** AW;
    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_sched_fifo.sv
// Small synchronous FIFO buffering mul/div results awaiting the write port.
module wb_fifo
    import regfile_wb_sched_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  wb_req_t       din,
    input  logic          pop,
    output wb_req_t       dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    wb_req_t       mem_q [DEPTH];
    wb_req_t       mem_d [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    // Caller only pushes when not full and pops when not empty.
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (push) begin
            mem_d[wptr_q] = din;
            wptr_d        = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign dout  = mem_q[rptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/regfile_wb_sched.sv
// Shares the regfile write port between WB and mul/div results, and
// scoreboards outstanding mul/div destinations to stall decode on hazards.
module regfile_wb_sched
    import regfile_wb_sched_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_we,
    input  logic [AW-1:0]   pipe_waddr,
    input  logic [DW-1:0]   pipe_wdata,
    input  logic            md_issue,
    input  logic [AW-1:0]   md_issue_rd,
    input  logic            md_valid,
    input  logic [AW-1:0]   md_waddr,
    input  logic [DW-1:0]   md_wdata,
    output logic            md_ready,
    input  logic [AW-1:0]   dec_rs,
    input  logic [AW-1:0]   dec_rt,
    input  logic [AW-1:0]   dec_rd,
    input  logic            dec_wr,
    output logic            stall_dec,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [DW-1:0]   rf_wdata,
    output logic [NREG-1:0] busy_vec
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic            pipe_eff;
    logic            arb_pipe;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    wb_req_t         push_req;
    wb_req_t         head;
    logic [NREG-1:0] busy_q, busy_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            starve_sat;

    assign pipe_eff  = pipe_we & (pipe_waddr != REG_ZERO);
    assign arb_pipe  = ~rst & pipe_eff;
    assign fifo_pop  = ~rst & ~pipe_eff & ~fifo_empty;
    assign md_ready  = ~rst & (fifo_count < CW'(FIFO_DEPTH));
    // r0 results complete the handshake but never occupy a slot.
    assign fifo_push = md_valid & md_ready & (md_waddr != REG_ZERO);
    assign push_req  = '{addr: md_waddr, data: md_wdata};

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (push_req),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        unique case (1'b1)
            arb_pipe: begin
                rf_we    = 1'b1;
                rf_waddr = pipe_waddr;
                rf_wdata = pipe_wdata;
            end
            fifo_pop: begin
                rf_we    = 1'b1;
                rf_waddr = head.addr;
                rf_wdata = head.data;
            end
            default: ;
        endcase
    end

    // Clear before set so a reissue to the retiring register stays busy.
    always_comb begin
        busy_d = busy_q;
        if (fifo_pop) begin
            busy_d[head.addr] = 1'b0;
        end
        if (md_issue && (md_issue_rd != REG_ZERO)) begin
            busy_d[md_issue_rd] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    assign starve_sat = (starve_q == SW'(STARVE_LIMIT));

    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || fifo_pop) begin
            starve_d = '0;
        end else if (pipe_eff && !starve_sat) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= '0;
            starve_q <= '0;
        end else begin
            busy_q   <= busy_d;
            starve_q <= starve_d;
        end
    end

    assign stall_dec = ~rst & (busy_q[dec_rs] | busy_q[dec_rt]
                     | (dec_wr & busy_q[dec_rd])
                     | fifo_full | starve_sat);
    assign busy_vec  = busy_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed scenarios plus randomized traffic against a queue-based
// reference model of the write-port scheduler.
module tb_regfile_wb_sched;
    import regfile_wb_sched_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            pipe_we;
    logic [AW-1:0]   pipe_waddr;
    logic [DW-1:0]   pipe_wdata;
    logic            md_issue;
    logic [AW-1:0]   md_issue_rd;
    logic            md_valid;
    logic [AW-1:0]   md_waddr;
    logic [DW-1:0]   md_wdata;
    logic            md_ready;
    logic [AW-1:0]   dec_rs, dec_rt, dec_rd;
    logic            dec_wr;
    logic            stall_dec;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;
    logic [NREG-1:0] busy_vec;

    regfile_wb_sched #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .md_issue(md_issue), .md_issue_rd(md_issue_rd),
        .md_valid(md_valid), .md_waddr(md_waddr), .md_wdata(md_wdata),
        .md_ready(md_ready),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd), .dec_wr(dec_wr),
        .stall_dec(stall_dec),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t            m_q[$];
    ent_t            pend[$];
    logic [NREG-1:0] m_busy = '0;
    int              m_starve = 0;

    function automatic bit m_pe();
        return pipe_we && (pipe_waddr != 0);
    endfunction

    function automatic logic exp_we();
        if (rst) return 1'b0;
        return m_pe() || (m_q.size() > 0);
    endfunction

    function automatic logic [AW-1:0] exp_waddr();
        if (rst) return '0;
        if (m_pe()) return pipe_waddr;
        if (m_q.size() > 0) return m_q[0].addr;
        return '0;
    endfunction

    function automatic logic [DW-1:0] exp_wdata();
        if (rst) return '0;
        if (m_pe()) return pipe_wdata;
        if (m_q.size() > 0) return m_q[0].data;
        return '0;
    endfunction

    function automatic logic exp_ready();
        return !rst && (m_q.size() < DEPTH);
    endfunction

    function automatic logic exp_stall();
        if (rst) return 1'b0;
        return m_busy[dec_rs] || m_busy[dec_rt] || (dec_wr && m_busy[dec_rd])
            || (m_q.size() == DEPTH) || (m_starve == LIMIT);
    endfunction

    function automatic logic [AW-1:0] pick_free();
        logic [AW-1:0] a;
        for (int t = 0; t < 64; t++) begin
            a = AW'($urandom_range(0, NREG - 1));
            if (!m_busy[a]) return a;
        end
        return '0;
    endfunction

    task automatic idle();
        pipe_we = 0; pipe_waddr = '0; pipe_wdata = '0;
        md_issue = 0; md_issue_rd = '0;
        md_valid = 0; md_waddr = '0; md_wdata = '0;
        dec_rs = '0; dec_rt = '0; dec_rd = '0; dec_wr = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic tick();
        bit   pe, popped, acc;
        int   old_size;
        ent_t e;
        if (rst) begin
            m_q.delete();
            m_busy = '0;
            m_starve = 0;
        end else begin
            pe = m_pe();
            old_size = m_q.size();
            popped = !pe && (old_size > 0);
            acc = md_valid && (old_size < DEPTH);
            if (popped) begin
                m_busy[m_q[0].addr] = 1'b0;
                void'(m_q.pop_front());
            end
            if (acc && md_waddr != 0) begin
                e.addr = md_waddr;
                e.data = md_wdata;
                m_q.push_back(e);
            end
            if (md_issue && md_issue_rd != 0) m_busy[md_issue_rd] = 1'b1;
            if (old_size == 0 || popped) m_starve = 0;
            else if (pe && m_starve < LIMIT) m_starve++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; idle(); #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_rf_we: got %b want 0", rf_we); end
        checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL rst_md_ready: got %b want 0", md_ready); end
        checks++; if (stall_dec !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall_dec); end
        tick();
        rst = 0; #1;
        checks++; if (busy_vec !== '0) begin errors++; $display("FAIL post_rst_busy: got %h want 0", busy_vec); end
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", md_ready); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL post_rst_rf_we: got %b want 0", rf_we); end
    endtask

    task automatic test_md_basic();
        idle();
        md_issue = 1; md_issue_rd = 5; dec_wr = 1; dec_rd = 5; #1;
        checks++; if (stall_dec !== 1'b0) begin errors++; $display("FAIL basic_issue_stall: got %b want 0", stall_dec); end
        tick();
        idle(); dec_rs = 5; #1;
        checks++; if (busy_vec[5] !== 1'b1) begin errors++; $display("FAIL basic_busy5_set: got %b want 1", busy_vec[5]); end
        checks++; if (stall_dec !== 1'b1) begin errors++; $display("FAIL basic_raw_stall: got %b want 1", stall_dec); end
        tick(); tick();
        md_valid = 1; md_waddr = 5; md_wdata = 32'h1234; #1;
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", md_ready); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL basic_no_bypass: got %b want 0", rf_we); end
        tick();
        md_valid = 0; #1;
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h1234})
            begin errors++; $display("FAIL basic_write: got %b/%0d/%h want 1/5/1234", rf_we, rf_waddr, rf_wdata); end
        checks++; if (stall_dec !== 1'b1) begin errors++; $display("FAIL basic_stall_hold: got %b want 1", stall_dec); end
        tick();
        checks++; if (busy_vec[5] !== 1'b0) begin errors++; $display("FAIL basic_busy5_clr: got %b want 0", busy_vec[5]); end
        checks++; if (stall_dec !== 1'b0) begin errors++; $display("FAIL basic_stall_rel: got %b want 0", stall_dec); end
        idle();
    endtask

    task automatic test_priority_starve();
        idle(); md_issue = 1; md_issue_rd = 7; tick();
        idle(); md_valid = 1; md_waddr = 7; md_wdata = 32'hBB; tick();
        idle(); pipe_we = 1; pipe_waddr = 3; pipe_wdata = 32'hAA; #1;
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'hAA})
            begin errors++; $display("FAIL prio_pipe_first: got %b/%0d/%h want 1/3/aa", rf_we, rf_waddr, rf_wdata); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (stall_dec !== (i == 3))
                begin errors++; $display("FAIL starve_stall_%0d: got %b want %b", i, stall_dec, i == 3); end
        end
        pipe_we = 0; #1;
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'hBB})
            begin errors++; $display("FAIL prio_fifo_next: got %b/%0d/%h want 1/7/bb", rf_we, rf_waddr, rf_wdata); end
        tick();
        checks++; if (stall_dec !== 1'b0) begin errors++; $display("FAIL starve_release: got %b want 0", stall_dec); end
        checks++; if (busy_vec[7] !== 1'b0) begin errors++; $display("FAIL starve_busy7: got %b want 0", busy_vec[7]); end
    endtask

    task automatic test_fifo_full();
        idle();
        md_issue = 1; md_issue_rd = 10; tick();
        md_issue_rd = 11; tick();
        md_issue_rd = 12; tick();
        idle(); pipe_we = 1; pipe_waddr = 3; pipe_wdata = 32'h1;
        md_valid = 1; md_waddr = 10; md_wdata = 32'hA10; tick();
        md_waddr = 11; md_wdata = 32'hA11; #1;
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL full_second_ready: got %b want 1", md_ready); end
        tick();
        md_waddr = 12; md_wdata = 32'hA12; #1;
        checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %b want 0", md_ready); end
        checks++; if (stall_dec !== 1'b1) begin errors++; $display("FAIL full_stall: got %b want 1", stall_dec); end
        tick();
        checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL full_held: got %b want 0", md_ready); end
        pipe_we = 0; #1;
        checks++; if ({rf_waddr, rf_wdata} !== {5'd10, 32'hA10})
            begin errors++; $display("FAIL full_pop1: got %0d/%h want 10/a10", rf_waddr, rf_wdata); end
        checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL full_no_credit: got %b want 0", md_ready); end
        tick();
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %b want 1", md_ready); end
        checks++; if (rf_waddr !== 5'd11) begin errors++; $display("FAIL full_pop2: got %0d want 11", rf_waddr); end
        tick();
        md_valid = 0; #1;
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd12, 32'hA12})
            begin errors++; $display("FAIL full_third: got %b/%0d/%h want 1/12/a12", rf_we, rf_waddr, rf_wdata); end
        tick();
        checks++; if (busy_vec !== '0) begin errors++; $display("FAIL full_drained: got %h want 0", busy_vec); end
    endtask

    task automatic test_r0();
        idle(); pipe_we = 1; pipe_waddr = 0; pipe_wdata = 32'hFF; #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL r0_pipe_we: got %b want 0", rf_we); end
        tick();
        idle(); md_valid = 1; md_waddr = 0; md_wdata = 32'h77; #1;
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL r0_md_ready: got %b want 1", md_ready); end
        tick();
        idle(); #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL r0_md_dropped: got %b want 0", rf_we); end
        md_issue = 1; md_issue_rd = 0; tick();
        idle(); #1;
        checks++; if (busy_vec !== '0) begin errors++; $display("FAIL r0_busy: got %h want 0", busy_vec); end
    endtask

    task automatic test_set_wins();
        idle(); md_issue = 1; md_issue_rd = 8; tick();
        idle(); md_valid = 1; md_waddr = 8; md_wdata = 32'h88; tick();
        idle(); md_issue = 1; md_issue_rd = 8; #1;
        checks++; if ({rf_we, rf_waddr} !== {1'b1, 5'd8}) begin errors++; $display("FAIL setwin_pop: got %b/%0d want 1/8", rf_we, rf_waddr); end
        tick();
        idle(); dec_wr = 1; dec_rd = 8; #1;
        checks++; if (busy_vec[8] !== 1'b1) begin errors++; $display("FAIL setwin_busy8: got %b want 1", busy_vec[8]); end
        checks++; if (stall_dec !== 1'b1) begin errors++; $display("FAIL setwin_waw: got %b want 1", stall_dec); end
        idle();
    endtask

    task automatic test_reset_mid();
        idle(); md_issue = 1; md_issue_rd = 5; tick();
        md_issue_rd = 9; tick();
        idle(); pipe_we = 1; pipe_waddr = 3; pipe_wdata = 32'h3;
        md_valid = 1; md_waddr = 5; md_wdata = 32'h55; tick();
        md_waddr = 9; md_wdata = 32'h99; tick();
        idle(); #1;
        checks++; if ({busy_vec[9], busy_vec[5], md_ready} !== 3'b110)
            begin errors++; $display("FAIL mid_pre: got %b want 110", {busy_vec[9], busy_vec[5], md_ready}); end
        rst = 1; #1;
        checks++; if ({rf_we, md_ready, stall_dec} !== 3'b000)
            begin errors++; $display("FAIL mid_in_rst: got %b want 000", {rf_we, md_ready, stall_dec}); end
        tick();
        rst = 0; #1;
        checks++; if (busy_vec !== '0) begin errors++; $display("FAIL mid_busy: got %h want 0", busy_vec); end
        checks++; if ({md_ready, rf_we} !== 2'b10) begin errors++; $display("FAIL mid_ready_we: got %b want 10", {md_ready, rf_we}); end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_discard: got %b want 0", rf_we); end
    endtask

    task automatic test_random(input int n);
        bit   held = 0;
        bit   acc;
        ent_t e;
        for (int c = 0; c < n + 300; c++) begin
            bit gen;
            gen = (c < n);
            idle();
            if (gen && $urandom_range(0, 1) == 1) begin
                pipe_we = 1;
                pipe_waddr = ($urandom_range(0, 7) == 0) ? '0 : pick_free();
                pipe_wdata = $urandom;
            end
            if (pend.size() > 0 && (held || $urandom_range(0, 2) != 0)) begin
                md_valid = 1; md_waddr = pend[0].addr; md_wdata = pend[0].data;
                held = 1;
            end
            if (gen) begin
                dec_rs = AW'($urandom_range(0, NREG - 1));
                dec_rt = AW'($urandom_range(0, NREG - 1));
                dec_rd = AW'($urandom_range(0, NREG - 1));
                dec_wr = 1'($urandom_range(0, 1));
            end
            #1;
            if (gen && !exp_stall() && pend.size() < 4 && $urandom_range(0, 2) == 0) begin
                md_issue = 1; md_issue_rd = pick_free();
                dec_wr = 1; dec_rd = md_issue_rd;
                e.addr = md_issue_rd; e.data = $urandom;
                pend.push_back(e);
            end
            #1;
            checks++; if (rf_we !== exp_we()) begin errors++; $display("FAIL rnd_rf_we c%0d: got %b want %b", c, rf_we, exp_we()); end
            checks++; if (rf_waddr !== exp_waddr()) begin errors++; $display("FAIL rnd_waddr c%0d: got %0d want %0d", c, rf_waddr, exp_waddr()); end
            checks++; if (rf_wdata !== exp_wdata()) begin errors++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, rf_wdata, exp_wdata()); end
            checks++; if (md_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, md_ready, exp_ready()); end
            checks++; if (stall_dec !== exp_stall()) begin errors++; $display("FAIL rnd_stall c%0d: got %b want %b", c, stall_dec, exp_stall()); end
            checks++; if (busy_vec !== m_busy) begin errors++; $display("FAIL rnd_busy c%0d: got %h want %h", c, busy_vec, m_busy); end
            checks++; if (pipe_we && busy_vec[pipe_waddr]) begin errors++; $display("FAIL rnd_pipe_busy c%0d: got r%0d busy want free", c, pipe_waddr); end
            acc = md_valid && exp_ready();
            tick();
            if (acc) begin
                void'(pend.pop_front());
                held = 0;
            end
            if (!gen && pend.size() == 0 && m_q.size() == 0) break;
        end
        checks++; if (pend.size() != 0 || m_q.size() != 0)
            begin errors++; $display("FAIL rnd_drain: got %0d/%0d left want 0/0", pend.size(), m_q.size()); end
        idle(); #1;
        checks++; if (busy_vec !== '0) begin errors++; $display("FAIL rnd_final_busy: got %h want 0", busy_vec); end
    endtask

    initial begin
        test_reset();
        test_md_basic();
        test_priority_starve();
        test_fifo_full();
        test_r0();
        test_set_wins();
        test_reset_mid();
        test_random(600);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
